// File: rtl/nh_lcd_data_reader_pkg.sv
// Shared constants for the NH LCD GRAM read-back path.
// Define SIMULATION to shrink the ping-pong buffers to 4 words each.
package nh_lcd_data_reader_pkg;

  localparam logic [7:0] CMD_READ_MEM_START = 8'h2E;

`ifdef SIMULATION
  localparam int LCD_RD_BUF_AW = 2;
`else
  localparam int LCD_RD_BUF_AW = 12;
`endif

  localparam int FIFO_CNT_W = 24;

  typedef logic [1:0] pp_sel_t;

endpackage

// File: rtl/nh_lcd_data_reader_ppfifo.sv
// Single-clock ping-pong FIFO: writer fills a buffer then releases it,
// reader activates a committed buffer, strobes it out, releases it.
module ppfifo
  import nh_lcd_data_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output pp_sel_t               write_ready,
  input  pp_sel_t               write_activate,
  output logic [FIFO_CNT_W-1:0] write_fifo_size,
  input  logic                  write_strobe,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_ready,
  input  logic                  read_activate,
  output logic [FIFO_CNT_W-1:0] read_count,
  input  logic                  read_strobe,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [FIFO_CNT_W-1:0] DEPTH_W = FIFO_CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic [1:0]            full_q, full_d;
  pp_sel_t               wprev_q;
  logic [FIFO_CNT_W-1:0] cnt_q [2];
  logic [FIFO_CNT_W-1:0] cnt_d [2];
  logic [FIFO_CNT_W-1:0] wcnt_q, wcnt_d;
  logic [FIFO_CNT_W-1:0] rptr_q, rptr_d;
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic                  ract_q, ract_d;
  logic                  wr_en;

  assign write_fifo_size = DEPTH_W;
  assign wr_en = (write_activate != 2'b00) && write_strobe && (wcnt_q < DEPTH_W);
  assign read_data = mem[rsel_q][rptr_q[ADDRESS_WIDTH-1:0]];
  assign read_count = ract_q ? cnt_q[rsel_q] : '0;
  assign read_ready = full_q[rsel_q] && !ract_q;

  always_comb begin
    full_d = full_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    rptr_d = rptr_q;
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    ract_d = ract_q;
    write_ready = 2'b00;
    // Only the next buffer in ping-pong order is offered, and not while
    // its previous release is still being committed.
    write_ready[wsel_q] = !full_q[wsel_q] && !wprev_q[wsel_q];
    if (wr_en) wcnt_d = wcnt_q + 1'b1;
    if (wprev_q != 2'b00 && write_activate == 2'b00) begin
      if (wcnt_q != '0) begin
        full_d[wsel_q] = 1'b1;
        cnt_d[wsel_q] = wcnt_q;
        wsel_d = !wsel_q;
      end
      wcnt_d = '0;
    end
    if (!ract_q && read_activate && full_q[rsel_q]) ract_d = 1'b1;
    if (ract_q && read_strobe && rptr_q < cnt_q[rsel_q]) rptr_d = rptr_q + 1'b1;
    if (ract_q && !read_activate) begin
      ract_d = 1'b0;
      rptr_d = '0;
      full_d[rsel_q] = 1'b0;
      rsel_d = !rsel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wsel_q][wcnt_q[ADDRESS_WIDTH-1:0]] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      wprev_q <= '0;
      cnt_q <= '{default: '0};
      wcnt_q <= '0;
      rptr_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      ract_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wprev_q <= write_activate;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      rptr_q <= rptr_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      ract_q <= ract_d;
    end
  end

endmodule

// File: rtl/nh_lcd_data_reader.sv
// NH LCD GRAM read-back: reads RGB bytes per pixel into a ping-pong FIFO.
// Define NH_LCD_READ_DUMMY_EN to discard the panel's first (dummy) read byte.
module nh_lcd_data_reader
  import nh_lcd_data_reader_pkg::*;
#(
  parameter int BUFFER_SIZE = LCD_RD_BUF_AW,
  parameter int READ_WAIT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug,
  input  logic        i_enable,
  input  logic [31:0] i_num_pixels,
  output logic        o_finished,
  output logic        o_fifo_rdy,
  input  logic        i_fifo_act,
  input  logic        i_fifo_stb,
  output logic [23:0] o_fifo_size,
  output logic [31:0] o_fifo_data,
  output logic        o_cmd_mode,
  output logic [7:0]  o_data_out,
  input  logic [7:0]  i_data_in,
  output logic        o_write,
  output logic        o_read,
  output logic        o_data_out_en
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_GET_FIFO   = 4'd1;
  localparam logic [3:0] ST_SEND_CMD   = 4'd2;
  localparam logic [3:0] ST_CMD_HOLD   = 4'd3;
  localparam logic [3:0] ST_RD_STROBE  = 4'd4;
  localparam logic [3:0] ST_RD_RECOVER = 4'd5;
  localparam logic [3:0] ST_PUSH       = 4'd6;
  localparam logic [3:0] ST_DONE       = 4'd7;

`ifdef NH_LCD_READ_DUMMY_EN
  localparam logic DUMMY_EN = 1'b1;
`else
  localparam logic DUMMY_EN = 1'b0;
`endif

  localparam logic [3:0] RW_LAST = 4'(READ_WAIT);

  logic [3:0]  state_q, state_d;
  logic [31:0] pix_q, pix_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  chan_q, chan_d;
  logic [3:0]  wait_q, wait_d;
  logic        dummy_q, dummy_d;
  logic        hold_q, hold_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  pp_sel_t     wact_q, wact_d;
  logic        cmd_q, cmd_d, wr_q, wr_d, rd_q, rd_d;
  logic        den_q, den_d, fin_q, fin_d;
  logic [7:0]  dout_q, dout_d;
  logic        fin;

  pp_sel_t     wr_rdy;
  logic [23:0] fifo_size;
  logic        wstb;
  logic [31:0] wdata;

  assign wstb = state_q == ST_PUSH;
  assign wdata = {r_q, g_q, b_q, 8'h00};

  ppfifo #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(BUFFER_SIZE)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .write_ready    (wr_rdy),
    .write_activate (wact_q),
    .write_fifo_size(fifo_size),
    .write_strobe   (wstb),
    .write_data     (wdata),
    .read_ready     (o_fifo_rdy),
    .read_activate  (i_fifo_act),
    .read_count     (o_fifo_size),
    .read_strobe    (i_fifo_stb),
    .read_data      (o_fifo_data)
  );

  always_comb begin
    state_d = state_q;
    pix_d = pix_q;
    word_d = word_q;
    chan_d = chan_q;
    wait_d = wait_q;
    dummy_d = dummy_q;
    hold_d = hold_q;
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    wact_d = wact_q;
    fin = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!i_enable) begin
          hold_d = 1'b0;
        end else if (!hold_q) begin
          if (i_num_pixels == '0) begin
            fin = 1'b1;
            hold_d = 1'b1;
          end else begin
            state_d = ST_GET_FIFO;
          end
        end
      end
      ST_GET_FIFO: begin
        if (wact_q == 2'b00 && wr_rdy != 2'b00) begin
          wact_d = wr_rdy[0] ? 2'b01 : 2'b10;
          word_d = '0;
          chan_d = '0;
          wait_d = '0;
          state_d = (pix_q == '0) ? ST_SEND_CMD : ST_RD_STROBE;
        end
      end
      ST_SEND_CMD: state_d = ST_CMD_HOLD;
      ST_CMD_HOLD: begin
        state_d = ST_RD_STROBE;
        wait_d = '0;
        chan_d = '0;
        dummy_d = DUMMY_EN;
      end
      ST_RD_STROBE: begin
        if (wait_q == RW_LAST) begin
          state_d = ST_RD_RECOVER;
          if (!dummy_q) begin
            unique case (chan_q)
              2'd0: r_d = i_data_in;
              2'd1: g_d = i_data_in;
              default: b_d = i_data_in;
            endcase
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_RD_RECOVER: begin
        wait_d = '0;
        if (dummy_q) begin
          dummy_d = 1'b0;
          state_d = ST_RD_STROBE;
        end else if (chan_q == 2'd2) begin
          state_d = ST_PUSH;
        end else begin
          chan_d = chan_q + 2'd1;
          state_d = ST_RD_STROBE;
        end
      end
      ST_PUSH: begin
        pix_d = pix_q + 32'd1;
        word_d = word_q + 24'd1;
        chan_d = '0;
        wait_d = '0;
        if (pix_d == i_num_pixels) begin
          wact_d = 2'b00;
          state_d = ST_DONE;
        end else if (word_d == fifo_size) begin
          wact_d = 2'b00;
          state_d = ST_GET_FIFO;
        end else begin
          state_d = ST_RD_STROBE;
        end
      end
      ST_DONE: begin
        pix_d = '0;
        word_d = '0;
        hold_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort drops any partial pixel; a released buffer keeps its whole words.
    if (state_q != ST_IDLE && state_q != ST_DONE && !i_enable) begin
      state_d = ST_IDLE;
      wact_d = 2'b00;
      pix_d = '0;
      word_d = '0;
      chan_d = '0;
      wait_d = '0;
      dummy_d = 1'b0;
      fin = 1'b1;
    end
    wr_d = state_d == ST_SEND_CMD;
    cmd_d = !wr_d;
    dout_d = wr_d ? CMD_READ_MEM_START : 8'h00;
    rd_d = state_d == ST_RD_STROBE;
    den_d = !((state_d inside {ST_RD_STROBE, ST_RD_RECOVER, ST_PUSH}) ||
              (state_d == ST_GET_FIFO && pix_d != '0));
    fin_d = fin || state_d == ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pix_q <= '0;
      word_q <= '0;
      chan_q <= '0;
      wait_q <= '0;
      dummy_q <= 1'b0;
      hold_q <= 1'b0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      wact_q <= 2'b00;
      cmd_q <= 1'b1;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      den_q <= 1'b1;
      fin_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      word_q <= word_d;
      chan_q <= chan_d;
      wait_q <= wait_d;
      dummy_q <= dummy_d;
      hold_q <= hold_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      wact_q <= wact_d;
      cmd_q <= cmd_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      den_q <= den_d;
      fin_q <= fin_d;
      dout_q <= dout_d;
    end
  end

  assign o_cmd_mode = cmd_q;
  assign o_data_out = dout_q;
  assign o_write = wr_q;
  assign o_read = rd_q;
  assign o_data_out_en = den_q;
  assign o_finished = fin_q;
  assign debug = {16'h0000, state_q, i_data_in, 1'b0, rd_q, cmd_q, i_enable};

endmodule

// File: tb/tb_nh_lcd_data_reader.sv
// Scoreboard bench for nh_lcd_data_reader with a cyclic 11/22/33 panel model.
// Buffers are 4 words deep; host drains through the ppfifo read port.
module tb_nh_lcd_data_reader;

  localparam int RW = 1;
`ifdef NH_LCD_READ_DUMMY_EN
  localparam int DUM = 1;
  localparam logic [31:0] EXP_W = 32'h22331100;
`else
  localparam int DUM = 0;
  localparam logic [31:0] EXP_W = 32'h11223300;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] debug;
  logic        i_enable;
  logic [31:0] i_num_pixels;
  logic        o_finished;
  logic        o_fifo_rdy;
  logic        i_fifo_act;
  logic        i_fifo_stb;
  logic [23:0] o_fifo_size;
  logic [31:0] o_fifo_data;
  logic        o_cmd_mode;
  logic [7:0]  o_data_out;
  logic [7:0]  i_data_in;
  logic        o_write;
  logic        o_read;
  logic        o_data_out_en;

  always #5 clk = ~clk;

  nh_lcd_data_reader #(
    .BUFFER_SIZE(2),
    .READ_WAIT  (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .debug        (debug),
    .i_enable     (i_enable),
    .i_num_pixels (i_num_pixels),
    .o_finished   (o_finished),
    .o_fifo_rdy   (o_fifo_rdy),
    .i_fifo_act   (i_fifo_act),
    .i_fifo_stb   (i_fifo_stb),
    .o_fifo_size  (o_fifo_size),
    .o_fifo_data  (o_fifo_data),
    .o_cmd_mode   (o_cmd_mode),
    .o_data_out   (o_data_out),
    .i_data_in    (i_data_in),
    .o_write      (o_write),
    .o_read       (o_read),
    .o_data_out_en(o_data_out_en)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];
  int bufsz_q[$];

  // Panel model and bus monitors
  logic [7:0] pan [3] = '{8'h11, 8'h22, 8'h33};
  int pidx = 0;
  int run = 0;
  int rd_pulses = 0;
  int len_bad = 0;
  int en_bad = 0;
  int wr_cnt = 0;
  int fin_cnt = 0;
  logic [8:0] last_wr = '0;

  assign i_data_in = pan[pidx];

  always @(posedge clk) begin
    if (o_write) pidx <= 0;
    else if (run != 0 && !o_read) pidx <= (pidx == 2) ? 0 : pidx + 1;
    if (o_read) begin
      run <= run + 1;
    end else if (run != 0) begin
      rd_pulses <= rd_pulses + 1;
      if (run != RW + 1) len_bad <= len_bad + 1;
      run <= 0;
    end
    if (o_read && o_data_out_en) en_bad <= en_bad + 1;
    if (o_write) begin
      wr_cnt <= wr_cnt + 1;
      last_wr <= {o_cmd_mode, o_data_out};
    end
    if (o_finished) fin_cnt <= fin_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drain(input int words);
    int got_w;
    int t;
    int sz;
    got_w = 0;
    while (got_w < words) begin
      t = 0;
      while (!o_fifo_rdy && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!o_fifo_rdy) begin
        check("rdy_timeout", 32'(got_w), 32'(words));
        return;
      end
      i_fifo_act = 1'b1;
      @(negedge clk);
      @(negedge clk);
      sz = int'(o_fifo_size);
      bufsz_q.push_back(sz);
      for (int i = 0; i < sz; i++) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          check("fifo_data", o_fifo_data, sb_q.pop_front());
        end
        i_fifo_stb = 1'b1;
        @(negedge clk);
      end
      i_fifo_stb = 1'b0;
      i_fifo_act = 1'b0;
      @(negedge clk);
      got_w += sz;
      if (sz == 0) return;
    end
  endtask

  task automatic wait_fin(input int base);
    int t;
    t = 0;
    while (fin_cnt == base && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (fin_cnt == base) check("fin_timeout", 32'(fin_cnt - base), 32'd1);
  endtask

  task automatic stop_run();
    i_enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  int b_wr, b_fin, b_rd, b_len, b_en;

  task automatic snap();
    b_wr = wr_cnt;
    b_fin = fin_cnt;
    b_rd = rd_pulses;
    b_len = len_bad;
    b_en = en_bad;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    i_enable = 1'b0;
    i_num_pixels = '0;
    i_fifo_act = 1'b0;
    i_fifo_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_mode", 32'(o_cmd_mode), 32'd1);
    check("rst_data_out", 32'(o_data_out), 32'd0);
    check("rst_write", 32'(o_write), 32'd0);
    check("rst_read", 32'(o_read), 32'd0);
    check("rst_out_en", 32'(o_data_out_en), 32'd1);
    check("rst_finished", 32'(o_finished), 32'd0);
    check("rst_fifo_rdy", 32'(o_fifo_rdy), 32'd0);
    check("rst_state", 32'(debug[15:12]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two pixels, one buffer
    snap();
    repeat (2) sb_q.push_back(EXP_W);
    i_num_pixels = 32'd2;
    i_enable = 1'b1;
    drain(2);
    wait_fin(b_fin);
    stop_run();
    check("t1_writes", 32'(wr_cnt - b_wr), 32'd1);
    check("t1_cmd", 32'(last_wr), {23'd0, 1'b0, 8'h2E});
    check("t1_fin", 32'(fin_cnt - b_fin), 32'd1);
    check("t1_reads", 32'(rd_pulses - b_rd), 32'(6 + DUM));
    check("t1_rd_len", 32'(len_bad - b_len), 32'd0);
    check("t1_en_rd", 32'(en_bad - b_en), 32'd0);
    check("t1_sb_left", 32'(sb_q.size()), 32'd0);

    // Ten pixels with a stalled host
    snap();
    bufsz_q.delete();
    repeat (10) sb_q.push_back(EXP_W);
    i_num_pixels = 32'd10;
    i_enable = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_stall_reads", 32'(rd_pulses - b_rd), 32'(24 + DUM));
    repeat (50) @(negedge clk);
    check("t2_stall_hold", 32'(rd_pulses - b_rd), 32'(24 + DUM));
    check("t2_stall_rd_lo", 32'(o_read), 32'd0);
    check("t2_rdy", 32'(o_fifo_rdy), 32'd1);
    drain(10);
    wait_fin(b_fin);
    stop_run();
    check("t2_nbufs", 32'(bufsz_q.size()), 32'd3);
    if (bufsz_q.size() == 3) begin
      check("t2_buf0", 32'(bufsz_q[0]), 32'd4);
      check("t2_buf1", 32'(bufsz_q[1]), 32'd4);
      check("t2_buf2", 32'(bufsz_q[2]), 32'd2);
    end
    check("t2_reads", 32'(rd_pulses - b_rd), 32'(30 + DUM));
    check("t2_fin", 32'(fin_cnt - b_fin), 32'd1);
    check("t2_writes", 32'(wr_cnt - b_wr), 32'd1);
    check("t2_rd_len", 32'(len_bad - b_len), 32'd0);
    check("t2_en_rd", 32'(en_bad - b_en), 32'd0);

    // Abort after the G read of pixel 3
    snap();
    repeat (3) sb_q.push_back(EXP_W);
    i_num_pixels = 32'd10;
    i_enable = 1'b1;
    t = 0;
    while (rd_pulses - b_rd < 11 + DUM && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("t3_reach_g", 32'(rd_pulses - b_rd), 32'(11 + DUM));
    i_enable = 1'b0;
    @(negedge clk);
    check("t3_read_lo", 32'(o_read), 32'd0);
    check("t3_out_en", 32'(o_data_out_en), 32'd1);
    check("t3_fin_pulse", 32'(o_finished), 32'd1);
    repeat (5) @(negedge clk);
    check("t3_fin", 32'(fin_cnt - b_fin), 32'd1);
    bufsz_q.delete();
    drain(3);
    check("t3_words", 32'(bufsz_q.size() > 0 ? bufsz_q[0] : 0), 32'd3);
    check("t3_sb_left", 32'(sb_q.size()), 32'd0);

    // Restart after abort begins with the command again
    snap();
    repeat (2) sb_q.push_back(EXP_W);
    i_num_pixels = 32'd2;
    i_enable = 1'b1;
    drain(2);
    wait_fin(b_fin);
    stop_run();
    check("t4_writes", 32'(wr_cnt - b_wr), 32'd1);
    check("t4_cmd", 32'(last_wr), {23'd0, 1'b0, 8'h2E});
    check("t4_fin", 32'(fin_cnt - b_fin), 32'd1);

    // Zero pixels: finish pulse only
    snap();
    i_num_pixels = 32'd0;
    i_enable = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_fin", 32'(fin_cnt - b_fin), 32'd1);
    check("t5_writes", 32'(wr_cnt - b_wr), 32'd0);
    check("t5_reads", 32'(rd_pulses - b_rd), 32'd0);
    check("t5_rdy", 32'(o_fifo_rdy), 32'd0);
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
